// File: rtl/sum_serial_ctrl.sv
// Bit-serial adder controller: one full-adder cell plus carry flop, LSB first.
// Optional signed-overflow output ovf is enabled by defining SUM_SERIAL_OVF_EN.
module sum_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef SUM_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             sum_bit;
    logic             carry_next;

    // The single full-adder cell shared by every bit position.
    assign sum_bit    = op_a[0] ^ op_b[0] ^ carry;
    assign carry_next = (op_a[0] & op_b[0]) | (carry & (op_a[0] ^ op_b[0]));

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
`ifdef SUM_SERIAL_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    res   <= {sum_bit, res[WIDTH-1:1]};
                    carry <= carry_next;
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    cnt   <= cnt + 1'b1;
                    // Final bit: publish the completed result directly, including this cycle's sum bit.
                    if (cnt == LAST) begin
                        s     <= {sum_bit, res[WIDTH-1:1]};
                        cout  <= carry_next;
`ifdef SUM_SERIAL_OVF_EN
                        ovf   <= carry ^ carry_next;
`endif
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sum_serial_ctrl.md
SUM_SERIAL_CTRL -- requirements
Module: sum_serial_ctrl

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL provide port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide port start  input  1  request to begin one addition; sampled on rising clk.
REQ-005 SHALL provide port a  input  WIDTH  operand A; captured when start is accepted.
REQ-006 SHALL provide port b  input  WIDTH  operand B; captured when start is accepted.
REQ-007 SHALL provide port cin  input  1  carry-in; captured when start is accepted.
REQ-008 SHALL provide port busy  output  1  high while an addition is in progress.
REQ-009 SHALL provide port done  output  1  single-cycle pulse marking a valid new result.
REQ-010 SHALL provide port s  output  WIDTH  registered sum of the last completed addition.
REQ-011 SHALL provide port cout  output  1  registered carry-out of the last completed addition.

Function
REQ-012 SHALL compute {cout,s} = a + b + cin bit-serially, using exactly one 1-bit full-adder cell plus a carry flip-flop, LSB first.
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-014 SHALL, in IDLE with start=1, load a, b, cin into internal shift/carry registers, clear bit counter, go to RUN.
REQ-015 SHALL, in each RUN cycle, add the operand LSBs and the carry flop, shift the sum bit into an internal result register from the MSB side, update the carry flop, shift both operands right, increment the counter.
REQ-016 SHALL leave RUN after exactly WIDTH cycles, copy internal result to s and final carry to cout on that edge, and enter DONE.
REQ-017 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE unconditionally.
REQ-018 SHALL produce latency: start accepted at edge k -> done high during cycle following edge k+WIDTH; next start accepted no earlier than edge k+WIDTH+2.
REQ-019 SHALL drive busy high in RUN and DONE, low in IDLE.
REQ-020 SHALL ignore start in RUN and DONE; operands and in-flight computation unaffected.
REQ-021 SHALL hold s and cout stable between done pulses; partial results never visible on s.
REQ-022 SHALL treat arithmetic as unsigned modulo 2^WIDTH with carry on cout; a+b+cin = 2^(WIDTH+1)-1 max, no wider output.
REQ-023 SHALL not require a, b, cin stable after the accepting edge.

Reset
REQ-024 SHALL, on rst=1 at any time, asynchronously force state IDLE, busy=0, done=0, s=0, cout=0, clear counter, carry flop and internal operand/result registers.
REQ-025 SHALL abort any in-flight addition on reset mid-RUN without emitting done; first start after rst deasserts is accepted normally.

Configuration
REQ-026 SHALL, when macro SUM_SERIAL_OVF_EN is defined, add port ovf  output  1  signed two's-complement overflow flag, updated with s/cout at RUN exit = carry into MSB XOR carry out of MSB, reset 0, held like s.
REQ-027 SHALL, when SUM_SERIAL_OVF_EN is undefined, have no ovf port and no associated logic; all other behaviour identical.

Verification (WIDTH=8)
REQ-028 SHALL cover: start with a=0x00,b=0x00,cin=0 at edge 0 -> busy 1 from edge 0, done pulse after edge 8, s=0x00, cout=0.
REQ-029 SHALL cover: a=0xFF,b=0x01,cin=0 -> s=0x00, cout=1; a=0xA5,b=0x5A,cin=1 -> s=0x00, cout=1; a=0x12,b=0x34,cin=0 -> s=0x46, cout=0.
REQ-030 SHALL cover: second start pulsed with a=0x01 at RUN cycle 3 -> ignored, first result delivered unchanged, only one done pulse.
REQ-031 SHALL cover: rst asserted between clock edges at RUN cycle 4 -> busy, done, s, cout drop to 0 immediately, no done; next start with 0x03+0x04 -> s=0x07.
REQ-032 SHALL cover, with SUM_SERIAL_OVF_EN defined: a=0x7F,b=0x01,cin=0 -> s=0x80, cout=0, ovf=1; a=0xFF,b=0xFF,cin=0 -> s=0xFE, cout=1, ovf=0.
